// File: rtl/mem_bist_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bist_ctrl
//
// Built-in self-test initiator for the dual-port RAM. After a start request it
// acquires the RAM through the valid/ready handshake. It writes the pattern
// exp(a) = a XOR seed to every location, then reads every location back and
// compares each word against the same pattern. It reports a mismatch count,
// the first failing address and a pass flag.
//
// Ports
//   clk_i             single clock, all state changes on the rising edge
//   rst_i             synchronous active-low reset (0 = reset)
//   start_i           start request, only looked at while idle
//   seed_i            pattern seed, captured when a start is accepted
//   valid_o           transaction request towards the RAM
//   ready_i           RAM ready
//   wr_en_o           RAM write enable (only while ready_i=1)
//   rd_en_o           RAM read enable  (only while ready_i=1)
//   wr_addr_o         RAM write address
//   rd_addr_o         RAM read address
//   wr_data_o         RAM write data
//   rd_data_i         RAM read data, valid the cycle after rd_en_o is sampled
//   busy_o            test in progress
//   done_o            one-cycle pulse when a test completes
//   pass_o            last completed test had no mismatches, held until next start
//   err_cnt_o         number of mismatching words in the last/current test
//   first_err_addr_o  address of the first mismatch, 0 if none
// -----------------------------------------------------------------------------
module mem_bist_ctrl #(
  parameter int MEM_DEPTH  = 128,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  wr_en_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

  // Width wide enough to hold both an address and a data word, so the
  // address can be zero-extended before the XOR with the seed.
  localparam int EXT_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);
  localparam logic [ADDR_WIDTH:0]   ERR_ONE   = (ADDR_WIDTH + 1)'(1'b1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACQ     = 3'd1,
    S_WRITE   = 3'd2,
    S_READ    = 3'd3,
    S_DRAIN   = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  // Expected word for an address: zero-extended address XOR seed,
  // truncated to the data width.
  function automatic logic [DATA_WIDTH-1:0] f_exp(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] s
  );
    logic [EXT_W-1:0] ext;
    ext                 = '0;
    ext[ADDR_WIDTH-1:0] = a;
    return ext[DATA_WIDTH-1:0] ^ s;
  endfunction

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_seed;
  logic                  r_cmp_vld;
  logic [ADDR_WIDTH-1:0] r_cmp_addr;
  logic [ADDR_WIDTH:0]   r_err_cnt;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;
  logic                  r_done;
  logic                  r_pass;

  state_t                w_next_state;
  logic                  w_valid;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_adv;
  logic                  w_start;
  logic                  w_done;
  logic                  w_mismatch;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and per-state handshake/enable generation.
  always_comb begin
    w_next_state = r_state;
    w_valid      = 1'b0;
    w_wr_en      = 1'b0;
    w_rd_en      = 1'b0;
    w_adv        = 1'b0;
    w_start      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_start      = 1'b1;
          w_next_state = S_ACQ;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ACQ: begin
        w_valid = 1'b1;
        if (ready_i) begin
          w_next_state = S_WRITE;
        end else begin
          w_next_state = S_ACQ;
        end
      end
      S_WRITE: begin
        // A ready_i=0 cycle is a stall: no enable and the address holds.
        w_valid = 1'b1;
        w_wr_en = ready_i;
        w_adv   = ready_i;
        if (ready_i && (r_addr == LAST_ADDR)) begin
          w_next_state = S_READ;
        end else begin
          w_next_state = S_WRITE;
        end
      end
      S_READ: begin
        w_valid = 1'b1;
        w_rd_en = ready_i;
        w_adv   = ready_i;
        if (ready_i && (r_addr == LAST_ADDR)) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_READ;
        end
      end
      S_DRAIN: begin
        // Holds the RAM for one more cycle so the final read gets compared.
        w_valid      = 1'b1;
        w_next_state = S_RELEASE;
      end
      S_RELEASE: begin
        if (!ready_i) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_RELEASE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // The read data arrives one cycle after the read is issued, so it is
  // checked against the address captured with that read.
  assign w_mismatch = r_cmp_vld && (rd_data_i != f_exp(r_cmp_addr, r_seed));

  // Address walker, seed capture, compare pipeline and result registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_addr           <= '0;
      r_seed           <= '0;
      r_cmp_vld        <= 1'b0;
      r_cmp_addr       <= '0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
    end else begin
      r_done     <= w_done;
      r_cmp_vld  <= w_rd_en;
      r_cmp_addr <= r_addr;
      if (w_start) begin
        r_seed           <= seed_i;
        r_addr           <= '0;
        r_err_cnt        <= '0;
        r_first_err_addr <= '0;
        r_pass           <= 1'b0;
      end else begin
        if (w_adv) begin
          r_addr <= (r_addr == LAST_ADDR) ? '0 : (r_addr + ADDR_ONE);
        end else begin
          r_addr <= r_addr;
        end
        if (w_mismatch) begin
          r_err_cnt <= r_err_cnt + ERR_ONE;
          if (r_err_cnt == '0) begin
            r_first_err_addr <= r_cmp_addr;
          end else begin
            r_first_err_addr <= r_first_err_addr;
          end
        end else begin
          r_err_cnt <= r_err_cnt;
        end
        // The last compare retires in DRAIN, so the count is final here.
        if (w_done) begin
          r_pass <= (r_err_cnt == '0);
        end else begin
          r_pass <= r_pass;
        end
      end
    end
  end

  assign valid_o          = w_valid;
  assign wr_en_o          = w_wr_en;
  assign rd_en_o          = w_rd_en;
  assign wr_addr_o        = (r_state == S_WRITE) ? r_addr : '0;
  assign rd_addr_o        = (r_state == S_READ)  ? r_addr : '0;
  assign wr_data_o        = (r_state == S_WRITE) ? f_exp(r_addr, r_seed) : '0;
  assign busy_o           = (r_state != S_IDLE);
  assign done_o           = r_done;
  assign pass_o           = r_pass;
  assign err_cnt_o        = r_err_cnt;
  assign first_err_addr_o = r_first_err_addr;

endmodule
